// File: rtl/dmem_responder_if.sv
// MEM-stage data-memory request/response bundle between the CPU pipeline and the memory responder.
interface dmem_responder_if;
    logic        req_i;
    logic        we_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic [31:0] rdata_o;
    logic        ack_o;
    logic        err_o;
    logic        stall_o;

    modport master (
        output req_i, we_i, addr_i, wdata_i,
        input  rdata_o, ack_o, err_o, stall_o
    );

    modport slave (
        input  req_i, we_i, addr_i, wdata_i,
        output rdata_o, ack_o, err_o, stall_o
    );
endinterface

// File: rtl/dmem_responder.sv
// Multi-cycle data memory: accepts one load/store, stalls the pipeline for LATENCY wait
// states, performs the access, then returns a single-cycle ack with read data or error.
module dmem_responder #(
    parameter int unsigned DEPTH   = 32,
    parameter int unsigned LATENCY = 3
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    dmem_responder_if.slave   bus
);
    localparam int unsigned IDX_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic                we_q;
    logic [DATA_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   rdata_q;
    logic                ack_q;
    logic                err_q;

    logic [DATA_W-1:0]   mem [DEPTH];

    logic [IDX_W-1:0]    idx_c;
    logic                addr_err_c;
    logic                access_c;

    // Out-of-range means any address bit above the word index is set.
    assign idx_c      = addr_q[IDX_W+1:2];
    assign addr_err_c = (addr_q[1:0] != 2'b00) || (addr_q[DATA_W-1:IDX_W+2] != '0);
    assign access_c   = (state == BUSY) && (cnt == '0);

    // Control FSM with registered completion outputs.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state   <= IDLE;
            cnt     <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    ack_q   <= 1'b0;
                    err_q   <= 1'b0;
                    rdata_q <= '0;
                    if (bus.req_i) begin
                        we_q    <= bus.we_i;
                        addr_q  <= bus.addr_i;
                        wdata_q <= bus.wdata_i;
                        cnt     <= CNT_W'(LATENCY - 1);
                        state   <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt == '0) begin
                        state   <= DONE;
                        ack_q   <= 1'b1;
                        err_q   <= addr_err_c;
                        rdata_q <= (!we_q && !addr_err_c) ? mem[idx_c] : '0;
                    end else begin
                        cnt <= CNT_W'(cnt - CNT_W'(1));
                    end
                end
                DONE: begin
                    ack_q   <= 1'b0;
                    err_q   <= 1'b0;
                    rdata_q <= '0;
                    state   <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Storage array is deliberately not reset; an aborted request never reaches the access edge.
    always_ff @(posedge clk_i) begin
        if (access_c && we_q && !addr_err_c) begin
            mem[idx_c] <= wdata_q;
        end
    end

    // Stall freezes the pipeline in the accept cycle and through all wait states.
    assign bus.stall_o = rst_n_i && ((state == IDLE) ? bus.req_i : (state == BUSY));
    assign bus.ack_o   = ack_q;
    assign bus.err_o   = err_q;
    assign bus.rdata_o = rdata_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: one instance with LATENCY=3, one with LATENCY=1.
module tb_dmem_responder;
    logic clk;
    logic rst3;
    logic rst1;

    int checks   = 0;
    int failures = 0;

    logic [32:0] q3[$];
    logic [32:0] q1[$];

    dmem_responder_if bus3();
    dmem_responder_if bus1();

    dmem_responder #(.DEPTH(32), .LATENCY(3)) dut3 (
        .clk_i   (clk),
        .rst_n_i (rst3),
        .bus     (bus3)
    );

    dmem_responder #(.DEPTH(32), .LATENCY(1)) dut1 (
        .clk_i   (clk),
        .rst_n_i (rst1),
        .bus     (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Completion monitors pop the expected {err, rdata} pushed when the request was driven.
    always @(negedge clk) begin
        logic [32:0] e;
        if (bus3.ack_o === 1'b1) begin
            chk("sb3_pending", 32'(q3.size() != 0), 32'd1);
            if (q3.size() != 0) begin
                e = q3.pop_front();
                chk("sb3_err", 32'(bus3.err_o), 32'(e[32]));
                chk("sb3_rdata", bus3.rdata_o, e[31:0]);
            end
        end else begin
            chk("l3_idle_err", {bus3.err_o, bus3.rdata_o != 32'd0}, 32'd0);
        end
    end

    always @(negedge clk) begin
        logic [32:0] e;
        if (bus1.ack_o === 1'b1) begin
            chk("sb1_pending", 32'(q1.size() != 0), 32'd1);
            if (q1.size() != 0) begin
                e = q1.pop_front();
                chk("sb1_err", 32'(bus1.err_o), 32'(e[32]));
                chk("sb1_rdata", bus1.rdata_o, e[31:0]);
            end
        end
    end

    // Drives a request in the current (negedge-aligned) cycle T and walks it to completion.
    task automatic do_req3(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic exp_err, input logic [31:0] exp_rdata, input bit scramble);
        bus3.req_i   = 1'b1;
        bus3.we_i    = we;
        bus3.addr_i  = addr;
        bus3.wdata_i = wdata;
        q3.push_back({exp_err, exp_rdata});
        #1;
        chk("l3_stall_accept", 32'(bus3.stall_o), 32'd1);
        chk("l3_ack_accept", 32'(bus3.ack_o), 32'd0);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (scramble && c <= 3) begin
                bus3.req_i   = 1'($urandom_range(0, 1));
                bus3.we_i    = 1'($urandom_range(0, 1));
                bus3.addr_i  = $urandom;
                bus3.wdata_i = $urandom;
            end else begin
                bus3.req_i   = 1'b0;
                bus3.we_i    = 1'b0;
                bus3.addr_i  = '0;
                bus3.wdata_i = '0;
            end
            #1;
            chk("l3_stall_wait", 32'(bus3.stall_o), 32'(c <= 3));
            chk("l3_ack_timing", 32'(bus3.ack_o), 32'(c == 4));
        end
        @(negedge clk);
    endtask

    initial begin
        bus3.req_i = 1'b0; bus3.we_i = 1'b0; bus3.addr_i = '0; bus3.wdata_i = '0;
        bus1.req_i = 1'b0; bus1.we_i = 1'b0; bus1.addr_i = '0; bus1.wdata_i = '0;
        rst3 = 1'b0;
        rst1 = 1'b0;

        // Reset held with a pending request: nothing may complete.
        bus3.req_i = 1'b1; bus3.we_i = 1'b1; bus3.addr_i = 32'h0; bus3.wdata_i = 32'h0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_ack", 32'(bus3.ack_o), 32'd0);
        chk("rst_err", 32'(bus3.err_o), 32'd0);
        chk("rst_rdata", bus3.rdata_o, 32'd0);
        chk("rst_stall", 32'(bus3.stall_o), 32'd0);
        @(negedge clk);
        rst3 = 1'b1;
        do_req3(1'b1, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);

        // Basic store then load.
        do_req3(1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0);
        do_req3(1'b0, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF, 1'b0);

        // Error cases must not write or alias onto valid words.
        do_req3(1'b1, 32'h12, 32'h11111111, 1'b1, 32'h0, 1'b0);
        do_req3(1'b0, 32'h80, 32'h0, 1'b1, 32'h0, 1'b0);
        do_req3(1'b1, 32'h90, 32'hBAD0BAD0, 1'b1, 32'h0, 1'b0);
        do_req3(1'b0, 32'h7D, 32'h0, 1'b1, 32'h0, 1'b0);
        do_req3(1'b0, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF, 1'b0);
        do_req3(1'b1, 32'h7C, 32'h0BADF00D, 1'b0, 32'h0, 1'b0);
        do_req3(1'b0, 32'h7C, 32'h0, 1'b0, 32'h0BADF00D, 1'b0);

        // Inputs churning during wait states must be ignored.
        do_req3(1'b1, 32'h24, 32'hCAFEF00D, 1'b0, 32'h0, 1'b1);
        do_req3(1'b0, 32'h24, 32'h0, 1'b0, 32'hCAFEF00D, 1'b1);
        do_req3(1'b0, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF, 1'b1);

        // Reset in the middle of a store aborts it.
        do_req3(1'b1, 32'h20, 32'h5555AAAA, 1'b0, 32'h0, 1'b0);
        bus3.req_i = 1'b1; bus3.we_i = 1'b1; bus3.addr_i = 32'h20; bus3.wdata_i = 32'h1234;
        @(negedge clk);
        bus3.req_i = 1'b0; bus3.we_i = 1'b0; bus3.addr_i = '0; bus3.wdata_i = '0;
        @(negedge clk);
        rst3 = 1'b0;
        #1;
        chk("abort_stall", 32'(bus3.stall_o), 32'd0);
        chk("abort_ack", 32'(bus3.ack_o), 32'd0);
        @(negedge clk);
        rst3 = 1'b1;
        repeat (5) begin
            @(negedge clk);
            #1;
            chk("abort_no_ack", 32'(bus3.ack_o), 32'd0);
            chk("abort_no_stall", 32'(bus3.stall_o), 32'd0);
        end
        @(negedge clk);
        do_req3(1'b0, 32'h20, 32'h0, 1'b0, 32'h5555AAAA, 1'b0);

        // LATENCY=1 with req held high: accept every third cycle, stall 1,1,0.
        @(negedge clk);
        rst1 = 1'b1;
        bus1.req_i = 1'b1;
        bus1.we_i  = 1'b1;
        bus1.addr_i = 32'h4;
        for (int k = 0; k < 9; k++) begin
            bus1.wdata_i = 32'h11110000 + 32'(k);
            if (k % 3 == 0) q1.push_back({1'b0, 32'h0});
            #1;
            chk("l1_stall_pattern", 32'(bus1.stall_o), 32'((k % 3) != 2));
            chk("l1_ack_pattern", 32'(bus1.ack_o), 32'((k % 3) == 2));
            @(negedge clk);
        end
        bus1.req_i = 1'b1;
        bus1.we_i  = 1'b0;
        bus1.wdata_i = 32'h0;
        q1.push_back({1'b0, 32'h11110006});
        @(negedge clk);
        bus1.req_i = 1'b0;
        @(negedge clk);
        #1;
        chk("l1_last_ack", 32'(bus1.ack_o), 32'd1);
        repeat (3) @(negedge clk);

        chk("sb3_drained", 32'(q3.size()), 32'd0);
        chk("sb1_drained", 32'(q1.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
